// File: rtl/chess_kbd_pkg.sv
// Shared constants for the chess move-entry keyboard path: PS/2 scan codes,
// entry FSM state encoding and default dmem addresses of the move mailbox.
package chess_kbd_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;

  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;

  localparam logic [11:0] DEF_SRC_ADDR  = 12'd64;
  localparam logic [11:0] DEF_DST_ADDR  = 12'd65;
  localparam logic [11:0] DEF_FLAG_ADDR = 12'd66;

  typedef enum logic [2:0] {
    SRC_ENTRY = 3'd0,
    SRC_WR    = 3'd1,
    DST_ENTRY = 3'd2,
    DST_WR    = 3'd3,
    FLAG_WR   = 3'd4,
    WAIT_ACK  = 3'd5
  } entry_state_e;

  function automatic logic [31:0] square_word(input logic [2:0] row, input logic [2:0] col);
    return {26'd0, row, col};
  endfunction

endpackage

// File: rtl/ps2_square_decoder.sv
// Combinational PS/2 make-code classifier: file letter a..h -> col 0..7,
// rank digit 1..8 -> row 0..7; anything else is neither.
module ps2_square_decoder
  import chess_kbd_pkg::*;
(
  input  logic [7:0] i_code,
  output logic       o_is_letter,
  output logic       o_is_digit,
  output logic [2:0] o_idx
);

  // Scan code lookup
  always_comb begin
    o_is_letter = 1'b0;
    o_is_digit  = 1'b0;
    o_idx       = 3'd0;
    case (i_code)
      SC_A: begin o_is_letter = 1'b1; o_idx = 3'd0; end
      SC_B: begin o_is_letter = 1'b1; o_idx = 3'd1; end
      SC_C: begin o_is_letter = 1'b1; o_idx = 3'd2; end
      SC_D: begin o_is_letter = 1'b1; o_idx = 3'd3; end
      SC_E: begin o_is_letter = 1'b1; o_idx = 3'd4; end
      SC_F: begin o_is_letter = 1'b1; o_idx = 3'd5; end
      SC_G: begin o_is_letter = 1'b1; o_idx = 3'd6; end
      SC_H: begin o_is_letter = 1'b1; o_idx = 3'd7; end
      SC_1: begin o_is_digit  = 1'b1; o_idx = 3'd0; end
      SC_2: begin o_is_digit  = 1'b1; o_idx = 3'd1; end
      SC_3: begin o_is_digit  = 1'b1; o_idx = 3'd2; end
      SC_4: begin o_is_digit  = 1'b1; o_idx = 3'd3; end
      SC_5: begin o_is_digit  = 1'b1; o_idx = 3'd4; end
      SC_6: begin o_is_digit  = 1'b1; o_idx = 3'd5; end
      SC_7: begin o_is_digit  = 1'b1; o_idx = 3'd6; end
      SC_8: begin o_is_digit  = 1'b1; o_idx = 3'd7; end
      default: begin
        o_is_letter = 1'b0;
        o_is_digit  = 1'b0;
        o_idx       = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/move_entry_arbiter.sv
// Keyboard move-entry sequencer sharing the dmem write port with the CPU (CPU wins).
// Optional macro SAME_SQUARE_REJECT_EN discards a destination equal to the source.
module move_entry_arbiter
  import chess_kbd_pkg::*;
#(
  parameter logic [11:0] SRC_ADDR     = DEF_SRC_ADDR,
  parameter logic [11:0] DST_ADDR     = DEF_DST_ADDR,
  parameter logic [11:0] FLAG_ADDR    = DEF_FLAG_ADDR,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  ps2_key_data,
  input  logic        ps2_key_pressed,
  input  logic        cpu_we,
  input  logic [11:0] cpu_write_address,
  input  logic [31:0] cpu_write_data,
  input  logic        move_consumed,
  output logic        dmem_we,
  output logic [11:0] dmem_write_address,
  output logic [31:0] dmem_write_data,
  output logic [2:0]  entry_state,
  output logic        kb_starved
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  entry_state_e     r_state;
  entry_state_e     w_next_state;
  logic             r_break_pending;
  logic             r_letter_valid;
  logic [2:0]       r_letter;
  logic             r_digit_valid;
  logic [2:0]       r_digit;
  logic [CNT_W-1:0] r_starve_cnt;

  logic       w_is_letter;
  logic       w_is_digit;
  logic [2:0] w_idx;
  logic       w_in_entry;
  logic       w_is_wr;
  logic       w_act;
  logic       w_grant;
  logic       w_done;
  logic       w_esc;
  logic       w_bksp;
  logic       w_same_sq;
  logic [5:0] w_square;
  logic [11:0] w_kb_addr;
  logic [31:0] w_kb_data;

  ps2_square_decoder u_dec (
    .i_code      (ps2_key_data),
    .o_is_letter (w_is_letter),
    .o_is_digit  (w_is_digit),
    .o_idx       (w_idx)
  );

  assign w_in_entry = (r_state == SRC_ENTRY) || (r_state == DST_ENTRY);
  assign w_is_wr    = (r_state == SRC_WR) || (r_state == DST_WR) || (r_state == FLAG_WR);
  assign w_act      = ps2_key_pressed && !r_break_pending && (ps2_key_data != SC_BREAK) && w_in_entry;
  assign w_grant    = w_is_wr && !cpu_we;
  assign w_done     = r_letter_valid && r_digit_valid;
  assign w_square   = {r_digit, r_letter};
  assign w_esc      = w_act && (ps2_key_data == SC_ESC) && (r_state == DST_ENTRY);
  assign w_bksp     = w_act && (ps2_key_data == SC_BKSP);

`ifdef SAME_SQUARE_REJECT_EN
  logic [5:0] r_src_square;

  // Remember the committed source square for the same-square check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_src_square <= 6'd0;
    end else if (w_grant && (r_state == SRC_WR)) begin
      r_src_square <= w_square;
    end else begin
      r_src_square <= r_src_square;
    end
  end

  assign w_same_sq = (r_state == DST_ENTRY) && w_done && (w_square == r_src_square);
`else
  assign w_same_sq = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SRC_ENTRY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; write states only advance on a grant
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SRC_ENTRY: if (w_done) w_next_state = SRC_WR; else w_next_state = SRC_ENTRY;
      SRC_WR:    if (w_grant) w_next_state = DST_ENTRY; else w_next_state = SRC_WR;
      DST_ENTRY: begin
        if (w_esc) begin
          w_next_state = SRC_ENTRY;
        end else if (w_done && !w_same_sq) begin
          w_next_state = DST_WR;
        end else begin
          w_next_state = DST_ENTRY;
        end
      end
      DST_WR:    if (w_grant) w_next_state = FLAG_WR; else w_next_state = DST_WR;
      FLAG_WR:   if (w_grant) w_next_state = WAIT_ACK; else w_next_state = FLAG_WR;
      WAIT_ACK:  if (move_consumed) w_next_state = SRC_ENTRY; else w_next_state = WAIT_ACK;
      default:   w_next_state = SRC_ENTRY;
    endcase
  end

  // Output mux: keyboard owns the port only on a grant
  always_comb begin
    w_kb_addr = SRC_ADDR;
    w_kb_data = 32'd0;
    case (r_state)
      SRC_WR:  begin w_kb_addr = SRC_ADDR;  w_kb_data = square_word(r_digit, r_letter); end
      DST_WR:  begin w_kb_addr = DST_ADDR;  w_kb_data = square_word(r_digit, r_letter); end
      FLAG_WR: begin w_kb_addr = FLAG_ADDR; w_kb_data = 32'd1; end
      default: begin w_kb_addr = SRC_ADDR;  w_kb_data = 32'd0; end
    endcase
    if (w_grant) begin
      dmem_we            = 1'b1;
      dmem_write_address = w_kb_addr;
      dmem_write_data    = w_kb_data;
    end else begin
      dmem_we            = cpu_we;
      dmem_write_address = cpu_write_address;
      dmem_write_data    = cpu_write_data;
    end
  end

  // Break-code tracking: the code after F0 is a release and is swallowed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_break_pending <= 1'b0;
    end else if (ps2_key_pressed) begin
      if (r_break_pending) begin
        r_break_pending <= 1'b0;
      end else if (ps2_key_data == SC_BREAK) begin
        r_break_pending <= 1'b1;
      end else begin
        r_break_pending <= r_break_pending;
      end
    end else begin
      r_break_pending <= r_break_pending;
    end
  end

  // Partial letter/digit capture, cleared on commit, edit keys or rejection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_letter_valid <= 1'b0;
      r_letter       <= 3'd0;
      r_digit_valid  <= 1'b0;
      r_digit        <= 3'd0;
    end else if ((w_grant && (r_state != FLAG_WR)) || w_esc || w_bksp || w_same_sq) begin
      r_letter_valid <= 1'b0;
      r_letter       <= 3'd0;
      r_digit_valid  <= 1'b0;
      r_digit        <= 3'd0;
    end else if (w_act && w_is_letter) begin
      r_letter_valid <= 1'b1;
      r_letter       <= w_idx;
    end else if (w_act && w_is_digit) begin
      r_digit_valid  <= 1'b1;
      r_digit        <= w_idx;
    end else begin
      r_letter_valid <= r_letter_valid;
      r_digit_valid  <= r_digit_valid;
    end
  end

  // Starvation counter: saturating count of denied write cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant || !w_is_wr) begin
      r_starve_cnt <= '0;
    end else if (cpu_we && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end

  assign kb_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign entry_state = r_state;

endmodule

// File: tb/tb_move_entry_arbiter.sv
// Directed bench for move_entry_arbiter; observed bundle = {we, addr, data, state}.
module tb_move_entry_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ps2_key_data = 8'h00;
  logic        ps2_key_pressed = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_write_address = 12'h000;
  logic [31:0] cpu_write_data = 32'h0;
  logic        move_consumed = 1'b0;
  logic        dmem_we;
  logic [11:0] dmem_write_address;
  logic [31:0] dmem_write_data;
  logic [2:0]  entry_state;
  logic        kb_starved;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [47:0] exp;

  move_entry_arbiter dut (
    .clock              (clock),
    .reset              (reset),
    .ps2_key_data       (ps2_key_data),
    .ps2_key_pressed    (ps2_key_pressed),
    .cpu_we             (cpu_we),
    .cpu_write_address  (cpu_write_address),
    .cpu_write_data     (cpu_write_data),
    .move_consumed      (move_consumed),
    .dmem_we            (dmem_we),
    .dmem_write_address (dmem_write_address),
    .dmem_write_data    (dmem_write_data),
    .entry_state        (entry_state),
    .kb_starved         (kb_starved)
  );

  always #5 clock = ~clock;

  function automatic logic [47:0] snap();
    return {dmem_we, dmem_write_address, dmem_write_data, entry_state};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_key(input logic [7:0] code);
    ps2_key_data = code;
    ps2_key_pressed = 1'b1;
    tick();
    ps2_key_pressed = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cpu_we = 1'b0;
    cpu_write_address = 12'h000;
    cpu_write_data = 32'h0;
    ps2_key_pressed = 1'b0;
    move_consumed = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_we = 1'b1;
    cpu_write_address = 12'h123;
    cpu_write_data = 32'hA5A5A5A5;
    #1;
    exp = {1'b1, 12'h123, 32'hA5A5A5A5, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL reset_passthru got=%h exp=%h", snap(), exp); else pass_cnt++;
    total_cnt++; if (kb_starved !== 1'b0) $display("FAIL reset_starved got=%b exp=0", kb_starved); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_full_move();
    do_reset();
    send_key(8'h24);
    send_key(8'h1E);
    exp = {1'b0, 12'd0, 32'd0, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL src_latency got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    exp = {1'b1, 12'd64, 32'h0C, 3'd1};
    total_cnt++; if (snap() !== exp) $display("FAIL src_write got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    exp = {1'b0, 12'd0, 32'd0, 3'd2};
    total_cnt++; if (snap() !== exp) $display("FAIL dst_entry got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h24);
    send_key(8'h25);
    tick();
    exp = {1'b1, 12'd65, 32'h1C, 3'd3};
    total_cnt++; if (snap() !== exp) $display("FAIL dst_write got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    exp = {1'b1, 12'd66, 32'd1, 3'd4};
    total_cnt++; if (snap() !== exp) $display("FAIL flag_write got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    exp = {1'b0, 12'd0, 32'd0, 3'd5};
    total_cnt++; if (snap() !== exp) $display("FAIL wait_ack got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h1C);
    tick();
    total_cnt++; if (snap() !== exp) $display("FAIL wait_ack_key got=%h exp=%h", snap(), exp); else pass_cnt++;
    move_consumed = 1'b1;
    tick();
    move_consumed = 1'b0;
    exp = {1'b0, 12'd0, 32'd0, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL consumed got=%h exp=%h", snap(), exp); else pass_cnt++;
    // Letter typed during WAIT_ACK must not have been kept
    send_key(8'h16);
    tick();
    tick();
    total_cnt++; if (snap() !== exp) $display("FAIL ack_key_ignored got=%h exp=%h", snap(), exp); else pass_cnt++;
  endtask

  task automatic test_break_filter();
    do_reset();
    send_key(8'h24);
    send_key(8'hF0);
    send_key(8'h24);
    send_key(8'hF0);
    send_key(8'h1E);
    tick();
    tick();
    exp = {1'b0, 12'd0, 32'd0, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL break_ignored got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h1E);
    tick();
    exp = {1'b1, 12'd64, 32'h0C, 3'd1};
    total_cnt++; if (snap() !== exp) $display("FAIL break_write got=%h exp=%h", snap(), exp); else pass_cnt++;
  endtask

  task automatic test_starve();
    logic [31:0] d;
    do_reset();
    cpu_we = 1'b1;
    cpu_write_address = 12'h200;
    send_key(8'h1C);
    send_key(8'h16);
    tick();
    for (int k = 1; k <= 20; k++) begin
      d = 32'hC0DE0000 + 32'(k);
      cpu_write_data = d;
      #1;
      exp = {1'b1, 12'h200, d, 3'd1};
      total_cnt++; if (snap() !== exp) $display("FAIL starve_passthru k=%0d got=%h exp=%h", k, snap(), exp); else pass_cnt++;
      total_cnt++; if (kb_starved !== (k >= 17)) $display("FAIL starve_flag k=%0d got=%b exp=%b", k, kb_starved, (k >= 17)); else pass_cnt++;
      tick();
    end
    cpu_we = 1'b0;
    #1;
    exp = {1'b1, 12'd64, 32'h00, 3'd1};
    total_cnt++; if (snap() !== exp) $display("FAIL starve_grant got=%h exp=%h", snap(), exp); else pass_cnt++;
    total_cnt++; if (kb_starved !== 1'b1) $display("FAIL starve_sat got=%b exp=1", kb_starved); else pass_cnt++;
    tick();
    exp = {1'b0, 12'h200, 32'hC0DE0014, 3'd2};
    total_cnt++; if (snap() !== exp) $display("FAIL starve_after got=%h exp=%h", snap(), exp); else pass_cnt++;
    total_cnt++; if (kb_starved !== 1'b0) $display("FAIL starve_clear got=%b exp=0", kb_starved); else pass_cnt++;
  endtask

  task automatic test_edit_keys();
    do_reset();
    send_key(8'h1C);
    send_key(8'h66);
    send_key(8'h16);
    tick();
    tick();
    exp = {1'b0, 12'd0, 32'd0, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL backspace got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h1C);
    tick();
    exp = {1'b1, 12'd64, 32'h00, 3'd1};
    total_cnt++; if (snap() !== exp) $display("FAIL bksp_write got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    send_key(8'h24);
    send_key(8'h76);
    exp = {1'b0, 12'd0, 32'd0, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL esc got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h1E);
    tick();
    tick();
    total_cnt++; if (snap() !== exp) $display("FAIL esc_cleared got=%h exp=%h", snap(), exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_key(8'h33);
    send_key(8'h3E);
    tick();
    tick();
    cpu_we = 1'b1;
    cpu_write_address = 12'h300;
    cpu_write_data = 32'h55;
    send_key(8'h24);
    send_key(8'h25);
    tick();
    exp = {1'b1, 12'h300, 32'h55, 3'd3};
    total_cnt++; if (snap() !== exp) $display("FAIL dst_blocked got=%h exp=%h", snap(), exp); else pass_cnt++;
    reset = 1'b0;
    #1;
    exp = {1'b1, 12'h300, 32'h55, 3'd0};
    total_cnt++; if (snap() !== exp) $display("FAIL async_reset got=%h exp=%h", snap(), exp); else pass_cnt++;
    cpu_we = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = {1'b0, 12'h300, 32'h55, 3'd0};
      total_cnt++; if (snap() !== exp) $display("FAIL post_reset k=%0d got=%h exp=%h", k, snap(), exp); else pass_cnt++;
    end
  endtask

  task automatic test_same_square();
    do_reset();
    send_key(8'h1C);
    send_key(8'h16);
    tick();
    tick();
    send_key(8'h1C);
    send_key(8'h16);
    tick();
`ifdef SAME_SQUARE_REJECT_EN
    exp = {1'b0, 12'd0, 32'd0, 3'd2};
    total_cnt++; if (snap() !== exp) $display("FAIL same_sq_reject got=%h exp=%h", snap(), exp); else pass_cnt++;
    tick();
    total_cnt++; if (snap() !== exp) $display("FAIL same_sq_stay got=%h exp=%h", snap(), exp); else pass_cnt++;
    send_key(8'h1C);
    send_key(8'h1E);
    tick();
    exp = {1'b1, 12'd65, 32'h08, 3'd3};
    total_cnt++; if (snap() !== exp) $display("FAIL diff_sq_write got=%h exp=%h", snap(), exp); else pass_cnt++;
`else
    exp = {1'b1, 12'd65, 32'h00, 3'd3};
    total_cnt++; if (snap() !== exp) $display("FAIL same_sq_write got=%h exp=%h", snap(), exp); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_full_move();
    test_break_filter();
    test_starve();
    test_edit_keys();
    test_reset_mid();
    test_same_square();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
